// File: rtl/dmem_dma_pkg.sv
// Shared types and helpers for the data-memory DMA engine.
// Holds the state encoding, mode codes and the overlap test.
package dmem_dma_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Copy must run backward when dst lies inside (src, src+len).
  function automatic logic is_backward(
    input logic [ADDR_W-1:0] src,
    input logic [ADDR_W-1:0] dst,
    input logic [ADDR_W-1:0] len
  );
    logic [ADDR_W-1:0] diff;
    diff = dst - src;
    return (dst != src) && (diff < len);
  endfunction

endpackage

// File: rtl/dmem_dma_ptr.sv
// Loadable address pointer that steps up or down by one.
// Wraps modulo 2**AW in both directions.
module dmem_dma_ptr #(
  parameter int AW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic          step,
  input  logic          down,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  always_ff @(posedge Clk) begin
    if (!Reset)
      ptr <= '0;
    else if (load)
      ptr <= base;
    else if (step)
      ptr <= down ? ptr - ONE : ptr + ONE;
  end

endmodule

// File: rtl/dmem_dma.sv
// Bulk copy (memmove) and fill engine for the 256x8 data memory.
// Owns the memory port while Busy is high.
module dmem_dma
  import dmem_dma_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Len,
  input  logic [DW-1:0] FillVal,
  input  logic [DW-1:0] MemDataIn,
  output logic [AW-1:0] MemAddr,
  output logic          MemWrEn,
  output logic [DW-1:0] MemDataOut,
  output logic          Busy,
  output logic          Done
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  dma_state_t    state, state_nx;
  logic          mode_q;
  logic          back_q;
  logic [AW-1:0] rem_q;
  logic [DW-1:0] hold_q;
  logic [DW-1:0] fill_q;
  logic [AW-1:0] src_ptr, dst_ptr;
  logic [AW-1:0] src_base, dst_base;
  logic          back;
  logic          load;
  logic          step;

  assign back = (Mode == MODE_COPY) &&
                is_backward(SrcAddr, DstAddr, Len);
  assign src_base = back ? SrcAddr + Len - ONE : SrcAddr;
  assign dst_base = back ? DstAddr + Len - ONE : DstAddr;
  assign load = (state == IDLE) && Start;
  assign step = (state == WR);

  dmem_dma_ptr #(.AW(AW)) u_src (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (load),
    .base  (src_base),
    .step  (step),
    .down  (back_q),
    .ptr   (src_ptr)
  );

  dmem_dma_ptr #(.AW(AW)) u_dst (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (load),
    .base  (dst_base),
    .step  (step),
    .down  (back_q),
    .ptr   (dst_ptr)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      back_q <= 1'b0;
      rem_q  <= '0;
      hold_q <= '0;
      fill_q <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        mode_q <= Mode;
        back_q <= back;
        rem_q  <= Len;
        fill_q <= FillVal;
      end
      if (state == RD)
        hold_q <= MemDataIn;
      if (state == WR)
        rem_q <= rem_q - ONE;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (Start) begin
          if (Len == '0)
            state_nx = DONE;
          else if (Mode == MODE_FILL)
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD: state_nx = WR;
      WR: begin
        if (rem_q == ONE)
          state_nx = DONE;
        else if (mode_q == MODE_COPY)
          state_nx = RD;
        else
          state_nx = WR;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    MemAddr    = '0;
    MemWrEn    = 1'b0;
    MemDataOut = '0;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (state)
      IDLE: ;
      RD: begin
        Busy    = 1'b1;
        MemAddr = src_ptr;
      end
      WR: begin
        Busy       = 1'b1;
        MemAddr    = dst_ptr;
        MemWrEn    = 1'b1;
        MemDataOut = (mode_q == MODE_FILL) ? fill_q : hold_q;
      end
      DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_dma.sv
// Directed bench: DMA plus a 256x8 memory behind a core/DMA port mux.
// Checks data placement, direction choice, latency, wrap and reset abort.
module tb_dmem_dma;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Mode = 1'b0;
  logic [7:0] SrcAddr = '0;
  logic [7:0] DstAddr = '0;
  logic [7:0] Len = '0;
  logic [7:0] FillVal = '0;
  logic [7:0] MemDataIn;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemDataOut;
  logic       Busy;
  logic       Done;

  logic [7:0] mem [256];
  logic [7:0] core_addr = '0;
  logic       core_we = 1'b0;
  logic [7:0] core_din = '0;
  logic [7:0] m_addr;
  logic       m_we;
  logic [7:0] m_din;
  int         wr_cnt = 0;
  int         tests = 0;
  int         fails = 0;

  always #5 Clk = ~Clk;

  assign m_addr = Busy ? MemAddr : core_addr;
  assign m_we = Busy ? MemWrEn : core_we;
  assign m_din = Busy ? MemDataOut : core_din;
  assign MemDataIn = mem[m_addr];

  always @(posedge Clk) begin
    if (m_we) mem[m_addr] <= m_din;
    if (MemWrEn) wr_cnt <= wr_cnt + 1;
  end

  dmem_dma dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Mode       (Mode),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Len        (Len),
    .FillVal    (FillVal),
    .MemDataIn  (MemDataIn),
    .MemAddr    (MemAddr),
    .MemWrEn    (MemWrEn),
    .MemDataOut (MemDataOut),
    .Busy       (Busy),
    .Done       (Done)
  );

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    core_addr = a;
    core_din = d;
    core_we = 1'b1;
    @(posedge Clk);
    #1;
    core_we = 1'b0;
  endtask

  // Launch a job and return the cycle in which Done was seen.
  task automatic run(input logic m, input logic [7:0] s,
                     input logic [7:0] d, input logic [7:0] n,
                     input logic [7:0] f, output int cyc);
    Mode = m;
    SrcAddr = s;
    DstAddr = d;
    Len = n;
    FillVal = f;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    cyc = 1;
    while (!Done && cyc < 600) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    tests++;
    if ({MemAddr, MemWrEn, MemDataOut, Busy, Done} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {MemAddr, MemWrEn, MemDataOut, Busy, Done});
    end
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) poke(i[7:0], 8'h00);
  endtask

  task automatic test_fill();
    int c;
    poke(8'h14, 8'h77);
    run(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, c);
    chk("fill_latency", c, 5);
    for (int i = 0; i < 4; i++)
      chk("fill_data", int'(mem[8'h10 + i]), 'hA5);
    chk("fill_beyond", int'(mem[8'h14]), 'h77);
    chk("fill_idle_busy", int'(Busy), 0);
  endtask

  task automatic test_copy();
    int c;
    poke(8'h00, 8'h11);
    poke(8'h01, 8'h22);
    poke(8'h02, 8'h33);
    run(1'b0, 8'h00, 8'h40, 8'd3, 8'h00, c);
    chk("copy_latency", c, 7);
    chk("copy_d0", int'(mem[8'h40]), 'h11);
    chk("copy_d1", int'(mem[8'h41]), 'h22);
    chk("copy_d2", int'(mem[8'h42]), 'h33);
    chk("copy_d3", int'(mem[8'h43]), 'h00);
  endtask

  task automatic test_overlap_back();
    int c;
    for (int i = 0; i < 4; i++) poke(8'h20 + i[7:0], i[7:0] + 8'd1);
    run(1'b0, 8'h20, 8'h22, 8'd4, 8'h00, c);
    chk("back_latency", c, 9);
    for (int i = 0; i < 4; i++)
      chk("back_data", int'(mem[8'h22 + i]), i + 1);
  endtask

  task automatic test_overlap_fwd();
    int c;
    for (int i = 0; i < 6; i++) poke(8'h20 + i[7:0], 8'h00);
    for (int i = 0; i < 4; i++) poke(8'h22 + i[7:0], i[7:0] + 8'd1);
    run(1'b0, 8'h22, 8'h20, 8'd4, 8'h00, c);
    for (int i = 0; i < 4; i++)
      chk("fwd_data", int'(mem[8'h20 + i]), i + 1);
  endtask

  task automatic test_fill_wrap();
    int c;
    poke(8'h02, 8'h99);
    run(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, c);
    chk("wrap_fe", int'(mem[8'hFE]), 'h5A);
    chk("wrap_ff", int'(mem[8'hFF]), 'h5A);
    chk("wrap_00", int'(mem[8'h00]), 'h5A);
    chk("wrap_01", int'(mem[8'h01]), 'h5A);
    chk("wrap_02", int'(mem[8'h02]), 'h99);
  endtask

  task automatic test_len_zero();
    int c;
    int w0;
    w0 = wr_cnt;
    run(1'b0, 8'h00, 8'h50, 8'd0, 8'h00, c);
    chk("len0_latency", c, 1);
    chk("len0_writes", wr_cnt - w0, 0);
  endtask

  task automatic test_start_ignored();
    int c;
    poke(8'h00, 8'h11);
    poke(8'h01, 8'h22);
    poke(8'h02, 8'h33);
    Mode = 1'b0;
    SrcAddr = 8'h00;
    DstAddr = 8'h60;
    Len = 8'd3;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    c = 1;
    while (!Done && c < 600) begin
      if (c == 3) begin
        Mode = 1'b1;
        DstAddr = 8'h80;
        Len = 8'd5;
        FillVal = 8'hEE;
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk);
      #1;
      c++;
    end
    Start = 1'b0;
    @(posedge Clk);
    #1;
    chk("ign_latency", c, 7);
    chk("ign_d0", int'(mem[8'h60]), 'h11);
    chk("ign_d2", int'(mem[8'h62]), 'h33);
    chk("ign_nofill", int'(mem[8'h80]), 'h00);
    chk("ign_idle", int'(Busy), 0);
  endtask

  task automatic test_reset_mid();
    int seen;
    Mode = 1'b0;
    SrcAddr = 8'h00;
    DstAddr = 8'h70;
    Len = 8'd4;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    chk("rst_wren", int'(MemWrEn), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_addr", int'(MemAddr), 0);
    seen = 0;
    repeat (12) begin
      if (Done) seen = 1;
      @(posedge Clk);
      #1;
    end
    chk("rst_no_done", seen, 0);
    chk("rst_kept", int'(mem[8'h70]), 'h11);
    chk("rst_abandon", int'(mem[8'h71]), 'h00);
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_copy();
    test_overlap_back();
    test_overlap_fwd();
    test_fill_wrap();
    test_len_zero();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
